// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 datapath blocks.
//   - SHA-256 initial hash values H0..H7 (IV), individually and packed
//   - DIGEST_W / HWORD_W widths of the full digest and of one hash word
//   - stream_state_t, the state type of the digest streamer FSM
package sha256_pkg;

  localparam int DIGEST_W = 256;
  localparam int HWORD_W  = 32;

  localparam logic [HWORD_W-1:0] IV_H0 = 32'h6a09e667;
  localparam logic [HWORD_W-1:0] IV_H1 = 32'hbb67ae85;
  localparam logic [HWORD_W-1:0] IV_H2 = 32'h3c6ef372;
  localparam logic [HWORD_W-1:0] IV_H3 = 32'ha54ff53a;
  localparam logic [HWORD_W-1:0] IV_H4 = 32'h510e527f;
  localparam logic [HWORD_W-1:0] IV_H5 = 32'h9b05688c;
  localparam logic [HWORD_W-1:0] IV_H6 = 32'h1f83d9ab;
  localparam logic [HWORD_W-1:0] IV_H7 = 32'h5be0cd19;

  // H0 sits in the most significant word, matching the h_in layout.
  localparam logic [DIGEST_W-1:0] IV = {IV_H0, IV_H1, IV_H2, IV_H3,
                                        IV_H4, IV_H5, IV_H6, IV_H7};

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/sha256_digest_streamer_if.sv
// sha256_digest_streamer_if
//   Bundles the digest capture side and the beat output side of the streamer.
//   Parameter OUT_W : output beat width (8, 16, 32 or 64).
//   Signals:
//     digest_valid  one-cycle pulse, h_in holds the final digest
//     h_in          {H0..H7}, H0 in [255:224]
//     digest_ready  streamer is idle and can capture a digest
//     out_data      current beat, out_valid / out_ready handshake
//     out_last      final beat of the digest
//     out_hit       difficulty result for the digest being streamed
//     overrun       sticky, a digest arrived while busy
//     clear_overrun synchronous clear of overrun
//   Modports:
//     master  the host / round-controller side driving the streamer
//     slave   the streamer itself
interface sha256_digest_streamer_if #(
  parameter int OUT_W = 32
);
  import sha256_pkg::*;

  logic                digest_valid;
  logic [DIGEST_W-1:0] h_in;
  logic                digest_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                out_hit;
  logic                overrun;
  logic                clear_overrun;

  modport master (
    output digest_valid, h_in, out_ready, clear_overrun,
    input  digest_ready, out_data, out_valid, out_last, out_hit, overrun
  );

  modport slave (
    input  digest_valid, h_in, out_ready, clear_overrun,
    output digest_ready, out_data, out_valid, out_last, out_hit, overrun
  );

endinterface

// File: rtl/lzc256.sv
// lzc256
//   Purely combinational leading-zero counter for a 256-bit word.
//   Ports:
//     x      in  256  word to examine, bit 255 is counted first
//     count  out 9    number of leading zeros, 256 for an all-zero word
//   Built as a balanced binary tree so it can be shared with the nonce
//   controller without a long serial priority chain.
module lzc256 (
  input  logic [255:0] x,
  output logic [8:0]   count
);

  // Each tree level merges adjacent pairs of nodes. A node covering 2*half
  // bits takes the left (more significant) count unless the left half is
  // entirely zero, in which case the right count is added on top of it.
  // Merging in place is safe because node i only reads nodes 2i and 2i+1,
  // which are never overwritten before they are read.
  function automatic logic [8:0] tree_lzc(input logic [255:0] v);
    logic [8:0] c [256];
    int         half;
    for (int i = 0; i < 256; i++) begin
      c[i] = {8'd0, ~v[255-i]};
    end
    for (int l = 0; l < 8; l++) begin
      half = 1 << l;
      for (int i = 0; i < 128; i++) begin
        if (i < (128 >> l)) begin
          c[i] = (c[2*i] == 9'(half)) ? 9'(half) + c[2*i+1] : c[2*i];
        end
      end
    end
    return c[0];
  endfunction

  assign count = tree_lzc(x);

endmodule

// File: rtl/sha256_digest_streamer.sv
// sha256_digest_streamer
//   Captures the final SHA-256 digest when the round controller pulses
//   digest_valid and streams it out as OUT_W-bit beats, H0 MSB first, over a
//   valid/ready handshake. Each digest is also tagged with a difficulty hit:
//   at least DIFF_BITS leading zero bits.
//   Parameters:
//     OUT_W     beat width, one of 8, 16, 32, 64
//     DIFF_BITS minimum leading zeros for a hit, 0..256 (0 = always a hit)
//   Ports:
//     clk    rising-edge system clock
//     rst_n  asynchronous active-low reset
//     bus    sha256_digest_streamer_if slave modport (digest capture side,
//            beat output side, overrun status and clear)
module sha256_digest_streamer
  import sha256_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter int DIFF_BITS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sha256_digest_streamer_if.slave   bus
);

  localparam int                BEATS     = DIGEST_W / OUT_W;
  localparam int                CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  // One extra bit so DIFF_BITS = 256 still compares correctly.
  localparam logic [9:0]        DIFF_Q    = 10'(DIFF_BITS);

  stream_state_t       state;
  stream_state_t       state_next;
  logic [DIGEST_W-1:0] shift_reg;
  logic [CNT_W-1:0]    beat_cnt;
  logic                hit_q;
  logic                overrun_q;
  logic [8:0]          lzc_count;
  logic                hit_next;
  logic                capture;
  logic                handshake;
  logic                is_last;

  logic                digest_ready_c;
  logic                out_valid_c;
  logic                out_last_c;
  logic                out_hit_c;
  logic [OUT_W-1:0]    out_data_c;

  lzc256 u_lzc (
    .x     (bus.h_in),
    .count (lzc_count)
  );

  assign hit_next  = ({1'b0, lzc_count} >= DIFF_Q);
  assign capture   = (state == IDLE) && bus.digest_valid;
  assign handshake = (state == STREAM) && bus.out_ready;
  assign is_last   = (beat_cnt == LAST_BEAT);

  // State register for the two-state capture/stream controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs. Outputs are gated by STREAM so that IDLE always
  // presents zeros regardless of what is left in the datapath registers.
  always_comb begin
    state_next     = state;
    digest_ready_c = 1'b0;
    out_valid_c    = 1'b0;
    out_last_c     = 1'b0;
    out_hit_c      = 1'b0;
    out_data_c     = '0;
    case (state)
      IDLE: begin
        digest_ready_c = 1'b1;
        if (bus.digest_valid) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        out_valid_c = 1'b1;
        out_last_c  = is_last;
        out_hit_c   = hit_q;
        out_data_c  = shift_reg[DIGEST_W-1 -: OUT_W];
        if (bus.out_ready && is_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Digest datapath: load on capture, shift one beat per accepted handshake.
  // Zero fill means nothing from the previous digest can reappear later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      beat_cnt  <= '0;
      hit_q     <= 1'b0;
    end else if (capture) begin
      shift_reg <= bus.h_in;
      beat_cnt  <= '0;
      hit_q     <= hit_next;
    end else if (handshake) begin
      shift_reg <= shift_reg << OUT_W;
      if (is_last) begin
        beat_cnt <= '0;
        hit_q    <= 1'b0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky overrun: any digest offered while streaming is dropped and
  // flagged. A new overrun beats a coincident clear so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (bus.digest_valid && (state == STREAM)) begin
      overrun_q <= 1'b1;
    end else if (bus.clear_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.digest_ready = digest_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_last     = out_last_c;
  assign bus.out_hit      = out_hit_c;
  assign bus.out_data     = out_data_c;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sha256_digest_streamer.sv
// tb_sha256_digest_streamer
//   Directed bench for sha256_digest_streamer. One instance uses 32-bit beats
//   with DIFF_BITS=16, a second uses 8-bit beats with the default difficulty.
//   A vector table drives whole digests (data, hit, backpressure pattern,
//   overrun injection); hand-written sequences cover overrun clearing,
//   mid-stream reset and the byte-wide instance.
module tb_sha256_digest_streamer;
  import sha256_pkg::*;

  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [15:0] PAT_ALL = 16'hffff;
  // Bit i is out_ready in stream cycle i: 1,0,0,1,0,1,1,0,1,1,0,1,0,1,1,1
  localparam logic [15:0] PAT_BP  = 16'b1110_1011_0110_1001;

  typedef struct {
    logic [255:0] h;
    logic         hit;
    logic [15:0]  ready;
    logic [7:0]   inject;
    int           cycles;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  int           checks = 0;
  int           errors = 0;
  logic         expOverrun = 1'b0;
  logic [255:0] abcVar;
  vec_t         vecs [7];

  always #5 clk = ~clk;

  sha256_digest_streamer_if #(.OUT_W(32)) bus32 ();
  sha256_digest_streamer_if #(.OUT_W(8))  bus8 ();

  sha256_digest_streamer #(.OUT_W(32), .DIFF_BITS(16)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  sha256_digest_streamer #(.OUT_W(8), .DIFF_BITS(32)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulses digest_valid on the 32-bit instance for one cycle; returns on the
  // falling edge after the capture edge.
  task automatic applyStimulus(input logic [255:0] h, input logic rdy);
    bus32.digest_valid = 1'b1;
    bus32.h_in         = h;
    bus32.out_ready    = rdy;
    @(negedge clk);
    bus32.digest_valid = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_valid"},   64'(bus32.out_valid),    64'(0));
    checkOutput({tag, "_last"},    64'(bus32.out_last),     64'(0));
    checkOutput({tag, "_data"},    64'(bus32.out_data),     64'(0));
    checkOutput({tag, "_hit"},     64'(bus32.out_hit),      64'(0));
    checkOutput({tag, "_dready"},  64'(bus32.digest_ready), 64'(1));
    checkOutput({tag, "_overrun"}, 64'(bus32.overrun),      64'(0));
    checkOutput({tag, "_valid8"},  64'(bus8.out_valid),     64'(0));
  endtask

  task automatic streamVector(input vec_t v);
    int          beat;
    int          cyc;
    logic        rdy;
    logic [31:0] expWord;
    checkOutput("idle_ready", 64'(bus32.digest_ready), 64'(1));
    checkOutput("idle_valid", 64'(bus32.out_valid), 64'(0));
    applyStimulus(v.h, v.ready[0]);
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 64) begin
      rdy = v.ready[cyc % 16];
      bus32.out_ready = rdy;
      if (v.inject[beat]) begin
        bus32.digest_valid = 1'b1;
        bus32.h_in         = ~v.h;
        expOverrun         = 1'b1;
      end
      expWord = v.h[255 - 32*beat -: 32];
      checkOutput("beat_valid", 64'(bus32.out_valid), 64'(1));
      checkOutput("beat_data",  64'(bus32.out_data),  64'(expWord));
      checkOutput("beat_last",  64'(bus32.out_last),  64'(beat == 7));
      checkOutput("beat_hit",   64'(bus32.out_hit),   64'(v.hit));
      @(negedge clk);
      bus32.digest_valid = 1'b0;
      if (rdy) beat++;
      cyc++;
    end
    bus32.out_ready = 1'b0;
    checkOutput("handshakes", 64'(beat), 64'(8));
    if (v.cycles != 0) checkOutput("stream_cycles", 64'(cyc), 64'(v.cycles));
    checkOutput("done_ready",   64'(bus32.digest_ready), 64'(1));
    checkOutput("done_valid",   64'(bus32.out_valid),    64'(0));
    checkOutput("done_overrun", 64'(bus32.overrun),      64'(expOverrun));
    @(negedge clk);
    checkOutput("no_extra_beat", 64'(bus32.out_valid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    abcVar = ABC;
    vecs[0] = '{h: ABC, hit: 1'b0, ready: PAT_ALL, inject: 8'h00, cycles: 8};
    vecs[1] = '{h: ABC, hit: 1'b0, ready: PAT_BP,  inject: 8'h00, cycles: 0};
    vecs[2] = '{h: {32'h0000ffff, {7{32'h5a5aa5a5}}}, hit: 1'b1, ready: PAT_ALL, inject: 8'h00, cycles: 8};
    vecs[3] = '{h: {32'h00010000, {7{32'hc3c3c3c3}}}, hit: 1'b0, ready: PAT_BP,  inject: 8'h00, cycles: 0};
    vecs[4] = '{h: 256'd0, hit: 1'b1, ready: PAT_ALL, inject: 8'h00, cycles: 8};
    vecs[5] = '{h: {32'h00000000, 32'h80000000, {6{32'h12345678}}}, hit: 1'b1, ready: PAT_ALL, inject: 8'h00, cycles: 8};
    vecs[6] = '{h: ABC, hit: 1'b0, ready: PAT_ALL, inject: 8'b1000_1000, cycles: 8};

    bus32.digest_valid  = 1'b0;
    bus32.h_in          = '0;
    bus32.out_ready     = 1'b0;
    bus32.clear_overrun = 1'b0;
    bus8.digest_valid   = 1'b0;
    bus8.h_in           = '0;
    bus8.out_ready      = 1'b0;
    bus8.clear_overrun  = 1'b0;

    #1 checkReset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      streamVector(vecs[i]);
    end

    // Clear alone drops the sticky flag on the next edge.
    bus32.clear_overrun = 1'b1;
    @(negedge clk);
    bus32.clear_overrun = 1'b0;
    checkOutput("overrun_cleared", 64'(bus32.overrun), 64'(0));
    expOverrun = 1'b0;

    // Clear coincident with a fresh overrun: set wins; held beat stays put.
    applyStimulus(ABC, 1'b0);
    bus32.digest_valid  = 1'b1;
    bus32.h_in          = ~ABC;
    bus32.clear_overrun = 1'b1;
    checkOutput("hold_valid", 64'(bus32.out_valid), 64'(1));
    checkOutput("hold_data",  64'(bus32.out_data),  64'(32'hba7816bf));
    @(negedge clk);
    bus32.digest_valid  = 1'b0;
    bus32.clear_overrun = 1'b0;
    checkOutput("overrun_set_wins", 64'(bus32.overrun),  64'(1));
    checkOutput("hold_data2",       64'(bus32.out_data), 64'(32'hba7816bf));
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("drain_data", 64'(bus32.out_data), 64'(abcVar[255 - 32*k -: 32]));
      checkOutput("drain_last", 64'(bus32.out_last), 64'(k == 7));
      @(negedge clk);
    end
    bus32.out_ready = 1'b0;
    checkOutput("drain_idle", 64'(bus32.out_valid), 64'(0));
    bus32.clear_overrun = 1'b1;
    @(negedge clk);
    bus32.clear_overrun = 1'b0;
    checkOutput("overrun_cleared2", 64'(bus32.overrun), 64'(0));

    // Reset in the middle of a stream, between clock edges.
    applyStimulus(ABC, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_data", 64'(bus32.out_data), 64'(32'hb00361a3));
    #2 rst_n = 1'b0;
    #1 checkReset("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus32.out_ready = 1'b0;
    @(negedge clk);
    streamVector(vecs[0]);

    // Byte-wide instance with the "abc" digest.
    bus8.digest_valid = 1'b1;
    bus8.h_in         = ABC;
    bus8.out_ready    = 1'b1;
    @(negedge clk);
    bus8.digest_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checkOutput("b8_valid", 64'(bus8.out_valid), 64'(1));
      checkOutput("b8_data",  64'(bus8.out_data),  64'(abcVar[255 - 8*k -: 8]));
      checkOutput("b8_last",  64'(bus8.out_last),  64'(k == 31));
      checkOutput("b8_hit",   64'(bus8.out_hit),   64'(0));
      if (k == 0)  checkOutput("b8_first",  64'(bus8.out_data), 64'(8'hba));
      if (k == 1)  checkOutput("b8_second", 64'(bus8.out_data), 64'(8'h78));
      if (k == 31) checkOutput("b8_final",  64'(bus8.out_data), 64'(8'had));
      @(negedge clk);
    end
    bus8.out_ready = 1'b0;
    checkOutput("b8_done_valid", 64'(bus8.out_valid),    64'(0));
    checkOutput("b8_done_ready", 64'(bus8.digest_ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
